shuffled_card_deck: RTL
=======================

# shuffled_card_deck

Shuffled 52-card shoe that feeds drawn cards to both hand controllers in the blackjack game. It fills a deck array after reset, Fisher-Yates shuffles it using a free-running LFSR, and then serves one card per accepted draw request. When the deck runs out, it reshuffles automatically. It sits directly upstream of the hand controllers; the game's combined player/dealer hit request drives its request input.

## Interface
Parameters:
- DECK_SIZE, 52: number of cards; must be 4 × 13.
- LFSR_SEED, 16'hACE1: LFSR value loaded on reset; must be non-zero.

Ports:
- i_clk  input  1  clock; one clock domain, all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_drawRequest  input  1  level request for one card; sampled only while o_ready=1.
- o_card  output  4  rank of the delivered card; 1=Ace … 11=J, 12=Q, 13=K; holds its last value between deliveries.
- o_cardValid  output  1  one-cycle pulse when o_card carries a newly dealt card.
- o_ready  output  1  deck is able to accept a request this cycle.
- o_shuffling  output  1  fill or shuffle is in progress.
- o_cardsRemaining  output  6  undealt cards, 0..52.

## Operation
- State machine: S_FILL → S_SHUFFLE → S_READY ⇄ S_DEAL; S_READY → S_FILL when the deck is empty.
- S_FILL (1 cycle):
  - deck[k] = (k mod 13)+1 for k = 0..51.
  - Shuffle index i = 51; deal pointer = 0.
- S_SHUFFLE, one attempt per cycle:
  - r = lfsr & mask(i), where mask(i) is the smallest 2^n−1 that is ≥ i.
  - If r ≤ i: swap deck[i] and deck[r], then decrement i.
  - Otherwise retry next cycle with no change.
  - When i = 0 after a swap, go to S_READY; o_cardsRemaining becomes 52.
- S_READY:
  - If o_cardsRemaining = 0, go to S_FILL (automatic reshuffle).
  - Else if i_drawRequest = 1: o_card ← deck[ptr], o_cardValid ← 1, ptr increments, o_cardsRemaining decrements, go to S_DEAL.
- S_DEAL (1 cycle):
  - o_cardValid returns to 0; o_ready = 0.
  - Return to S_READY.
  - A request held high therefore yields at most one card every 2 cycles.
- Requests while o_ready = 0 are ignored, not queued; the requester keeps its request high until it sees o_cardValid.
- LFSR:
  - 16-bit Galois, taps 16'hB400 (x^16+x^14+x^13+x^11+1).
  - Advances every cycle in every state, so shuffles after the first depend on request timing.
- Output flags: o_ready = (state == S_READY && o_cardsRemaining != 0); o_shuffling = state ∈ {S_FILL, S_SHUFFLE}.

## Timing
- Reset values: o_card = 0, o_cardValid = 0, o_ready = 0, o_shuffling = 1, o_cardsRemaining = 0, state = S_FILL, lfsr = LFSR_SEED.
- Reset mid-shuffle or mid-deal: the partial deck is abandoned and the sequence restarts from S_FILL with the seed.
- Request latency: request sampled at edge N → o_card/o_cardValid valid after edge N (registered), visible during cycle N+1.
- Shuffle duration:
  - 1 fill cycle plus 51 successful swaps, ≥ 52 cycles total.
  - Expected under 2 attempts per swap with the pow2 mask, under ~110 cycles typical.
  - Fully deterministic for a given seed and reset time.
- Last card: its delivery takes o_cardsRemaining to 0. The S_DEAL → S_READY → S_FILL path holds o_ready low throughout, and o_cardsRemaining reads 52 again when the shuffle ends.
- Simultaneous reset and request: reset wins, and no card is delivered.

## Configuration
- DECK_FIXED_ORDER_EN defined:
  - S_SHUFFLE is skipped; S_FILL goes directly to S_READY.
  - Cards are dealt in fill order 1,2,…,13,1,2,…
  - Used for directed game-level tests.
- Not defined: full LFSR Fisher-Yates shuffle as described above.

## Structure
- Shared package holds:
  - the card rank type (4-bit) and constants RANK_ACE = 1 … RANK_KING = 13;
  - DECK_SIZE;
  - the deck state encodings.
- One sub-module, deck_lfsr: 16-bit Galois LFSR with seed parameter, synchronous reset, and a 16-bit output.
- The deck array is 52 × 4-bit registers, not inferred RAM, so the swap completes in one cycle.

## Test plan
- DECK_FIXED_ORDER_EN, reset, then 14 held requests → o_cardValid pulses every 2 cycles with ranks 1..13 then 1; o_cardsRemaining = 38.
- Shuffled build, 52 requests → each rank 1..13 seen exactly 4 times; o_cardsRemaining reaches 0 and o_ready drops.
- Continue requesting after card 52 → o_shuffling = 1, no o_cardValid until reshuffle ends; o_cardsRemaining = 52; next card is delivered.
- Request asserted during initial shuffle → no o_cardValid until o_ready = 1, then exactly one card per 2 cycles.
- Reset asserted mid-shuffle, and again at the same point later → both first-deck sequences identical for LFSR_SEED = 16'hACE1.
- Reset asserted in the same cycle as a request in S_READY → o_cardValid stays 0; all outputs return to reset values.

Source files
------------

// File: rtl/shuffled_card_deck_pkg.sv
// Shared types and constants for the shuffled card deck: card ranks, deck
// geometry, LFSR taps and deck state encodings.
package shuffled_card_deck_pkg;

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned RANKS     = 13;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned RANK_W    = 4;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef logic [RANK_W-1:0] rank_t;

  localparam rank_t RANK_ACE   = 4'd1;
  localparam rank_t RANK_TWO   = 4'd2;
  localparam rank_t RANK_THREE = 4'd3;
  localparam rank_t RANK_FOUR  = 4'd4;
  localparam rank_t RANK_FIVE  = 4'd5;
  localparam rank_t RANK_SIX   = 4'd6;
  localparam rank_t RANK_SEVEN = 4'd7;
  localparam rank_t RANK_EIGHT = 4'd8;
  localparam rank_t RANK_NINE  = 4'd9;
  localparam rank_t RANK_TEN   = 4'd10;
  localparam rank_t RANK_JACK  = 4'd11;
  localparam rank_t RANK_QUEEN = 4'd12;
  localparam rank_t RANK_KING  = 4'd13;

  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_SHUFFLE = 2'd1,
    S_READY   = 2'd2,
    S_DEAL    = 2'd3
  } deck_state_e;

  // Smallest 2^n-1 that covers idx, so a masked LFSR draw lands in range often.
  function automatic logic [IDX_W-1:0] idx_mask(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] m;
    m = '0;
    for (int b = 0; b < int'(IDX_W); b++) begin
      if (m < idx) m = {m[IDX_W-2:0], 1'b1};
    end
    return m;
  endfunction

endpackage

// File: rtl/shuffled_card_deck_lfsr.sv
// deck_lfsr: free-running 16-bit Galois LFSR (taps 16'hB400), reloaded with
// SEED on synchronous reset.
module deck_lfsr
  import shuffled_card_deck_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic [LFSR_W-1:0] o_lfsr
);

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/shuffled_card_deck.sv
// Shuffled 52-card shoe: fill, Fisher-Yates shuffle from a free-running LFSR,
// then one card per accepted request. Define DECK_FIXED_ORDER_EN to skip the
// shuffle and deal in fill order.
module shuffled_card_deck
  import shuffled_card_deck_pkg::*;
#(
  parameter int unsigned       DECK_SIZE = shuffled_card_deck_pkg::DECK_SIZE,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_drawRequest,
  output logic [RANK_W-1:0] o_card,
  output logic              o_cardValid,
  output logic              o_ready,
  output logic              o_shuffling,
  output logic [IDX_W-1:0]  o_cardsRemaining
);

  deck_state_e r_state;
  deck_state_e w_state_next;

  rank_t            r_deck [DECK_SIZE];
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_remaining;
  rank_t            r_card;
  logic             r_card_valid;
  logic             r_ready;
  logic             r_shuffling;

  logic [LFSR_W-1:0] w_lfsr;
  logic [LFSR_W-1:0] w_pick;
  logic [IDX_W-1:0]  w_pick_idx;
  logic [IDX_W-1:0]  w_rem_next;
  logic              w_fill;
  logic              w_swap;
  logic              w_deal;

  deck_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_lfsr  (w_lfsr)
  );

  assign w_pick     = w_lfsr & LFSR_W'(idx_mask(r_idx));
  assign w_pick_idx = w_pick[IDX_W-1:0];

  // Next state and per-cycle datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_remaining;
    w_fill       = 1'b0;
    w_swap       = 1'b0;
    w_deal       = 1'b0;
    case (r_state)
      S_FILL: begin
        w_fill = 1'b1;
`ifdef DECK_FIXED_ORDER_EN
        w_state_next = S_READY;
        w_rem_next   = IDX_W'(DECK_SIZE);
`else
        w_state_next = S_SHUFFLE;
`endif
      end
      S_SHUFFLE: begin
        if (w_pick <= LFSR_W'(r_idx)) begin
          w_swap = 1'b1;
          if (r_idx == IDX_W'(1)) begin
            w_state_next = S_READY;
            w_rem_next   = IDX_W'(DECK_SIZE);
          end
        end
      end
      S_READY: begin
        if (r_remaining == '0) begin
          w_state_next = S_FILL;
        end else if (i_drawRequest) begin
          w_deal       = 1'b1;
          w_rem_next   = r_remaining - IDX_W'(1);
          w_state_next = S_DEAL;
        end
      end
      S_DEAL: begin
        w_state_next = S_READY;
      end
      default: begin
        w_state_next = S_FILL;
      end
    endcase
  end

  // State, pointers and registered outputs; flags are derived from next state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_FILL;
      r_idx        <= '0;
      r_ptr        <= '0;
      r_remaining  <= '0;
      r_card       <= '0;
      r_card_valid <= 1'b0;
      r_ready      <= 1'b0;
      r_shuffling  <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_remaining  <= w_rem_next;
      r_card_valid <= w_deal;
      r_ready      <= (w_state_next == S_READY) && (w_rem_next != '0);
      r_shuffling  <= (w_state_next == S_FILL) || (w_state_next == S_SHUFFLE);
      if (w_fill) begin
        r_idx <= IDX_W'(DECK_SIZE - 1);
        r_ptr <= '0;
      end else if (w_swap) begin
        r_idx <= r_idx - IDX_W'(1);
      end
      if (w_deal) begin
        r_card <= r_deck[r_ptr];
        r_ptr  <= r_ptr + IDX_W'(1);
      end
    end
  end

  // Deck is a flat register file so a swap of two arbitrary slots is one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int k = 0; k < int'(DECK_SIZE); k++) begin
        if (w_fill) begin
          r_deck[k] <= RANK_W'((k % int'(RANKS)) + 1);
        end else if (w_swap && (r_idx == IDX_W'(k))) begin
          r_deck[k] <= r_deck[w_pick_idx];
        end else if (w_swap && (w_pick_idx == IDX_W'(k))) begin
          r_deck[k] <= r_deck[r_idx];
        end
      end
    end
  end

  assign o_card           = r_card;
  assign o_cardValid      = r_card_valid;
  assign o_ready          = r_ready;
  assign o_shuffling      = r_shuffling;
  assign o_cardsRemaining = r_remaining;

endmodule
